// File: rtl/fifo_rd_tx_sched_pkg.sv
// Shared definitions for the FIFO read-side transmit scheduler.
//   - sched_state_e : 3-bit binary FSM state encoding
//   - DefaultGap    : system-wide inter-frame gap for the UART path
//   - DefaultBusyTo : system-wide tx_busy rise timeout for the UART path
//   - cnt_width()   : width of the shared WAIT_HI/GAP down-counter
package fifo_rd_tx_sched_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPop    = 3'd1,
    StStart  = 3'd2,
    StWaitHi = 3'd3,
    StWaitLo = 3'd4,
    StGap    = 3'd5
  } sched_state_e;

  localparam int unsigned DefaultGap    = 2;
  localparam int unsigned DefaultBusyTo = 16;

  // The counter only ever holds GAP-1 or BUSY_TO-1, so clog2 of the larger one suffices.
  // Clamped to 1 bit so a degenerate configuration still elaborates.
  function automatic int unsigned cnt_width(int unsigned gap, int unsigned busy_to);
    int unsigned m;
    m = (gap > busy_to) ? gap : busy_to;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fifo_rd_tx_sched_ctrl_down_cnt.sv
// Loadable down-counter with a zero flag, shared by the WAIT_HI timeout and the GAP delay.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i (has priority over dec_i)
//   load_val_i    : value to load
//   dec_i         : decrement by one, saturating at zero
//   zero_o        : counter currently holds zero
module fifo_rd_tx_sched_ctrl_down_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fifo_rd_tx_sched.sv
// Read-side sequencer: pops one word at a time from the async FIFO, hands it to a
// busy-signalled serial transmitter with a one-cycle start pulse, waits for the frame to
// finish, then inserts an inter-frame gap. Counts completed frames and flags tx_busy
// handshake timeouts.
//   clk_i, rst_ni   : read-domain clock, asynchronous active-low reset
//   enable_i        : allows new pops (sampled only in IDLE)
//   fifo_empty_i    : FIFO read-side empty flag
//   fifo_rd_data_i  : FIFO read data at the current read address
//   fifo_rd_inc_o   : one-cycle pop request to the FIFO read pointer
//   tx_data_o       : word presented to the transmitter
//   tx_valid_o      : one-cycle start pulse to the transmitter
//   tx_busy_i       : transmitter busy
//   frame_cnt_o     : completed-frame count (wraps)
//   busy_to_err_o   : sticky tx_busy-rise timeout flag
//   err_clr_i       : clears busy_to_err_o (a same-cycle set wins)
//   active_o        : high in every state except IDLE
module fifo_rd_tx_sched
  import fifo_rd_tx_sched_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned GAP     = DefaultGap,
  parameter int unsigned BUSY_TO = DefaultBusyTo,
  parameter int unsigned CW      = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic          fifo_empty_i,
  input  logic [W-1:0]  fifo_rd_data_i,
  output logic          fifo_rd_inc_o,
  output logic [W-1:0]  tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_busy_i,
  output logic [CW-1:0] frame_cnt_o,
  output logic          busy_to_err_o,
  input  logic          err_clr_i,
  output logic          active_o
);

  localparam int unsigned    CntW     = cnt_width(GAP, BUSY_TO);
  localparam logic [CntW-1:0] BusyToLd = CntW'(BUSY_TO - 1);
  localparam logic [CntW-1:0] GapLd    = CntW'((GAP > 0) ? GAP - 1 : 0);
  localparam bit              HasGap   = (GAP > 0);

  sched_state_e state_d, state_q;

  logic [W-1:0]  tx_data_d, tx_data_q;
  logic [CW-1:0] frame_cnt_d, frame_cnt_q;
  logic          busy_to_err_d, busy_to_err_q;

  logic            cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0] cnt_load_val;
  logic            err_set, frame_done;

  fifo_rd_tx_sched_ctrl_down_cnt #(
    .Width (CntW)
  ) u_down_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    err_set      = 1'b0;
    frame_done   = 1'b0;

    case (state_q)
      StIdle: begin
        // tx_busy high here means the transmitter is still draining; hold off the pop.
        if (enable_i && !fifo_empty_i && !tx_busy_i) begin
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StStart;
      end
      StStart: begin
        cnt_load     = 1'b1;
        cnt_load_val = BusyToLd;
        state_d      = StWaitHi;
      end
      StWaitHi: begin
        // busy is checked before the timeout so a rise on the final cycle still counts.
        if (tx_busy_i) begin
          state_d = StWaitLo;
        end else if (cnt_zero) begin
          err_set = 1'b1;
          if (HasGap) begin
            cnt_load     = 1'b1;
            cnt_load_val = GapLd;
            state_d      = StGap;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StWaitLo: begin
        if (!tx_busy_i) begin
          frame_done = 1'b1;
          if (HasGap) begin
            cnt_load     = 1'b1;
            cnt_load_val = GapLd;
            state_d      = StGap;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath next-state
  always_comb begin
    tx_data_d     = (state_q == StPop) ? fifo_rd_data_i : tx_data_q;
    frame_cnt_d   = frame_done ? (frame_cnt_q + CW'(1)) : frame_cnt_q;
    busy_to_err_d = busy_to_err_q;
    if (err_set) begin
      busy_to_err_d = 1'b1;
    end else if (err_clr_i) begin
      busy_to_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      tx_data_q     <= '0;
      frame_cnt_q   <= '0;
      busy_to_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      frame_cnt_q   <= frame_cnt_d;
      busy_to_err_q <= busy_to_err_d;
    end
  end

  // Moore outputs straight from the state register, so reset forces them immediately.
  assign fifo_rd_inc_o = (state_q == StPop);
  assign tx_valid_o    = (state_q == StStart);
  assign active_o      = (state_q != StIdle);
  assign tx_data_o     = tx_data_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign busy_to_err_o = busy_to_err_q;

endmodule

// File: tb/tb_fifo_rd_tx_sched.sv
// Randomized bench for fifo_rd_tx_sched with a FIFO model, a reactive transmitter model and
// a frame-level reference model predicting per-cycle outputs from the scheduling rules.
module tb_fifo_rd_tx_sched;

  localparam int unsigned W       = 8;
  localparam int unsigned GAP     = 2;
  localparam int unsigned BUSY_TO = 16;
  localparam int unsigned CW      = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rd_data;
  logic          fifo_rd_inc;
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic          tx_busy;
  logic [CW-1:0] frame_cnt;
  logic          busy_to_err;
  logic          err_clr;
  logic          active;

  fifo_rd_tx_sched #(
    .W       (W),
    .GAP     (GAP),
    .BUSY_TO (BUSY_TO),
    .CW      (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_rd_inc_o  (fifo_rd_inc),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .tx_busy_i      (tx_busy),
    .frame_cnt_o    (frame_cnt),
    .busy_to_err_o  (busy_to_err),
    .err_clr_i      (err_clr),
    .active_o       (active)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int          cyc    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
  endtask

  // Stimulus knobs
  int unsigned en_p = 0, push_p = 0, dead_p = 0, clr_p = 0;
  int unsigned dly_lo = 2, dly_hi = 2, len_lo = 10, len_hi = 10;
  bit          busy_force = 1'b0;
  bit          rel_rst = 1'b0;
  logic [W-1:0] push_q[$];

  // FIFO and transmitter models
  logic [W-1:0] fq[$];
  bit           pop_pend = 1'b0;
  int           busy_on = -1, busy_off = -1;
  int           f_dly = 2, f_len = 10;
  bit           f_dead = 1'b0;

  // Reference model: cycle numbers at which events become visible
  logic [W-1:0]  mq[$];
  int            m_pop = -1, m_start = -1, m_idle_from = 0, m_fc_at = -1, m_err_at = -1;
  logic [W-1:0]  m_txd = '0, m_txd_nxt = '0;
  logic [CW-1:0] m_fc = '0;
  bit            m_err = 1'b0;
  bit            clr_prev = 1'b0;

  task automatic step();
    logic [W-1:0] w;
    @(negedge clk);
    cyc++;
    if (cyc == m_start) m_txd = m_txd_nxt;
    if (cyc == m_fc_at) m_fc = m_fc + 1'b1;
    if (cyc == m_err_at) m_err = 1'b1;
    else if (clr_prev) m_err = 1'b0;

    check("fifo_rd_inc", fifo_rd_inc, cyc == m_pop);
    check("tx_valid", tx_valid, cyc == m_start);
    check("active", active, (m_pop >= 0) && (cyc >= m_pop) && (cyc < m_idle_from));
    check("tx_data", tx_data, m_txd);
    check("frame_cnt", frame_cnt, m_fc);
    check("busy_to_err", busy_to_err, m_err);

    if (rel_rst) begin
      rst_n   = 1'b1;
      rel_rst = 1'b0;
    end
    // A pop requested last cycle took effect at the edge just passed
    if (pop_pend && fq.size() > 0) void'(fq.pop_front());
    pop_pend = fifo_rd_inc;
    while (push_q.size() > 0) begin
      w = push_q.pop_front();
      fq.push_back(w);
      mq.push_back(w);
    end
    if (push_p > 0 && $urandom_range(99) < push_p && fq.size() < 8) begin
      w = W'($urandom);
      fq.push_back(w);
      mq.push_back(w);
    end
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = fifo_empty ? '0 : fq[0];
    if (tx_valid && !f_dead) begin
      busy_on  = cyc + f_dly;
      busy_off = busy_on + f_len;
    end
    tx_busy  = busy_force || (cyc >= busy_on && cyc < busy_off);
    enable   = ($urandom_range(99) < en_p);
    err_clr  = ($urandom_range(99) < clr_p);
    clr_prev = err_clr;

    // An IDLE decision this cycle: pop next cycle, start the one after
    if (rst_n && cyc >= m_idle_from && enable && mq.size() > 0 && !tx_busy) begin
      m_pop     = cyc + 1;
      m_start   = cyc + 2;
      m_txd_nxt = mq.pop_front();
      f_dead    = ($urandom_range(99) < dead_p);
      f_dly     = int'($urandom_range(dly_hi, dly_lo));
      f_len     = int'($urandom_range(len_hi, len_lo));
      if (f_dead) begin
        m_err_at    = m_start + BUSY_TO + 1;
        m_idle_from = m_err_at + GAP;
      end else begin
        m_fc_at     = m_start + f_dly + f_len + 1;
        m_idle_from = m_fc_at + GAP;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the DUT is in the busy-high part of a frame, bounded
  task automatic reach_wait_lo();
    bit reached = 1'b0;
    for (int i = 0; i < 80 && !reached; i++) begin
      step();
      if (active && tx_busy && !tx_valid) reached = 1'b1;
    end
    check("reach_wait_lo", reached, 1'b1);
    step();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_fifo_rd_inc", fifo_rd_inc, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_busy_to_err", busy_to_err, 0);
    check("rst_active", active, 0);
    m_pop = -1; m_start = -1; m_fc_at = -1; m_err_at = -1; m_idle_from = 0;
    m_txd = '0; m_fc = '0; m_err = 1'b0;
    busy_on = -1; busy_off = -1; tx_busy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0; tx_busy = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = '0;
    run(3);
    rel_rst = 1'b1;
    run(3);

    // Single word, busy 2 cycles after start for 10 cycles
    en_p = 100;
    push_q.push_back(8'hA5);
    run(30);

    // Three back-to-back words
    push_q.push_back(8'h01); push_q.push_back(8'h02); push_q.push_back(8'h03);
    run(70);

    // Transmitter never answers; then a lone clear; then clear held through the set
    dead_p = 100;
    push_q.push_back(8'h3C);
    run(30);
    clr_p = 100; step(); clr_p = 0;
    run(3);
    push_q.push_back(8'hC3);
    clr_p = 100;
    run(30);
    clr_p = 0; dead_p = 0;

    // Busy-on-last-WAIT_HI-cycle boundary
    dly_lo = BUSY_TO; dly_hi = BUSY_TO; len_lo = 3; len_hi = 3;
    push_q.push_back(8'h77);
    run(35);
    dly_lo = 2; dly_hi = 2; len_lo = 10; len_hi = 10;

    // Enable dropped mid-frame with two words queued
    push_q.push_back(8'h11); push_q.push_back(8'h22);
    reach_wait_lo();
    en_p = 0;
    run(40);
    en_p = 100;
    run(30);

    // Transmitter already busy while idle
    push_q.push_back(8'h5A);
    busy_force = 1'b1;
    run(10);
    busy_force = 1'b0;
    run(30);

    // Reset during WAIT_LO with one more word behind
    push_q.push_back(8'h81); push_q.push_back(8'h82);
    reach_wait_lo();
    async_reset();
    step();
    rel_rst = 1'b1;
    run(40);

    // Random traffic; long enough to wrap the 4-bit frame counter several times
    en_p = 80; push_p = 15; dead_p = 10; clr_p = 5;
    dly_lo = 1; dly_hi = BUSY_TO; len_lo = 1; len_hi = 12;
    run(3000);
    en_p = 100; push_p = 0; dead_p = 0; clr_p = 0;
    run(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
